// File: rtl/mux_4to1_nb.sv
// WIDTH-bit 4-to-1 bus multiplexer: combinational output oY plus a registered copy
// oY_q that is cleared asynchronously while iRst_n is low.
module mux_4to1_nb #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic [WIDTH-1:0] iC,
   input  logic [WIDTH-1:0] iD,
   input  logic [1:0]       iS,
   output logic [WIDTH-1:0] oY,
   input  logic             iClk,
   input  logic             iRst_n,
   output logic [WIDTH-1:0] oY_q
);

   logic [WIDTH-1:0] y_d;
   logic [WIDTH-1:0] y_q;

   // An X/Z select matches no leg, so the 'x default propagates to oY in simulation.
   always_comb begin
      y_d = 'x;
      case (iS)
         2'b00: y_d = iA;
         2'b01: y_d = iB;
         2'b10: y_d = iC;
         2'b11: y_d = iD;
      endcase
   end

   assign oY = y_d;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         y_q <= '0;
      end else begin
         y_q <= y_d;
      end
   end

   assign oY_q = y_q;

endmodule

// File: tb/tb_mux_4to1_nb.sv
// Scoreboarded bench for mux_4to1_nb: an 8-bit instance and a 4-bit instance fed with
// the low nibbles of the same buses, checked against hand-computed expectations.
module tb_mux_4to1_nb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, b, c, d;
   logic [1:0] s;
   logic [7:0] y8, q8;
   logic [3:0] y4, q4;

   always #5 clk = ~clk;

   mux_4to1_nb #(.WIDTH(8)) u_w8 (
      .iA(a), .iB(b), .iC(c), .iD(d), .iS(s), .oY(y8),
      .iClk(clk), .iRst_n(rst_n), .oY_q(q8)
   );

   mux_4to1_nb #(.WIDTH(4)) u_w4 (
      .iA(a[3:0]), .iB(b[3:0]), .iC(c[3:0]), .iD(d[3:0]), .iS(s), .oY(y4),
      .iClk(clk), .iRst_n(rst_n), .oY_q(q4)
   );

   typedef struct {
      string      name;
      bit         chk_y;
      logic [7:0] y8;
      logic [3:0] y4;
      bit         chk_q;
      logic [7:0] q8;
      logic [3:0] q4;
   } exp_t;

   exp_t exp_q[$];
   event push_ev;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void cmp(string n, logic [7:0] act, logic [7:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", n, act, want);
      end
   endfunction

   // Monitor: pops each expectation one timestep after it is issued and compares.
   initial begin
      exp_t e;
      forever begin
         @(push_ev);
         #1;
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.chk_y) begin
               cmp({e.name, "/oY8"}, y8, e.y8);
               cmp({e.name, "/oY4"}, {4'h0, y4}, {4'h0, e.y4});
            end
            if (e.chk_q) begin
               cmp({e.name, "/oYq8"}, q8, e.q8);
               cmp({e.name, "/oYq4"}, {4'h0, q4}, {4'h0, e.q4});
            end
         end
      end
   end

   task automatic expect_y(input string n, input logic [7:0] y8e, input logic [3:0] y4e);
      exp_t e;
      e = '{name: n, chk_y: 1'b1, y8: y8e, y4: y4e, chk_q: 1'b0, q8: 8'h00, q4: 4'h0};
      exp_q.push_back(e);
      -> push_ev;
      #2;
   endtask

   task automatic expect_yq(input string n, input logic [7:0] y8e, input logic [3:0] y4e,
                            input logic [7:0] q8e, input logic [3:0] q4e);
      exp_t e;
      e = '{name: n, chk_y: 1'b1, y8: y8e, y4: y4e, chk_q: 1'b1, q8: q8e, q4: q4e};
      exp_q.push_back(e);
      -> push_ev;
      #2;
   endtask

   task automatic drive(input logic [1:0] sv, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] cv, input logic [7:0] dv);
      s = sv; a = av; b = bv; c = cv; d = dv;
   endtask

   initial begin
      rst_n = 1'b1;
      drive(2'd0, 8'hA3, 8'h24, 8'h7E, 8'h10);
      #1 rst_n = 1'b0;
      expect_yq("rst_comb_valid", 8'hA3, 4'h3, 8'h00, 4'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk) #1;
         expect_yq("rst_hold", 8'hA3, 4'h3, 8'h00, 4'h0);
      end

      @(negedge clk);
      rst_n = 1'b1;
      drive(2'd2, 8'hA3, 8'h24, 8'h44, 8'h10);
      @(posedge clk) #1;
      expect_yq("release_load", 8'h44, 4'h4, 8'h44, 4'h4);

      @(negedge clk);
      drive(2'd0, 8'hA3, 8'h24, 8'h7E, 8'h10);
      expect_y("sel0", 8'hA3, 4'h3);
      a = 8'h55;
      expect_y("sel0_chg", 8'h55, 4'h5);
      @(posedge clk) #1;
      expect_yq("sel0_reg", 8'h55, 4'h5, 8'h55, 4'h5);

      @(negedge clk);
      drive(2'd1, 8'h2C, 8'hE7, 8'h08, 8'hAA);
      expect_y("sel1", 8'hE7, 4'h7);
      b = 8'hD2;
      expect_y("sel1_chg", 8'hD2, 4'h2);
      @(posedge clk) #1;
      expect_yq("sel1_reg", 8'hD2, 4'h2, 8'hD2, 4'h2);

      @(negedge clk);
      drive(2'd2, 8'h00, 8'h67, 8'h1E, 8'hA8);
      expect_y("sel2", 8'h1E, 4'hE);
      c = 8'h5C;
      expect_y("sel2_chg", 8'h5C, 4'hC);
      @(posedge clk) #1;
      expect_yq("sel2_reg", 8'h5C, 4'hC, 8'h5C, 4'hC);

      @(negedge clk);
      drive(2'd3, 8'hBE, 8'hDA, 8'hCE, 8'hEF);
      expect_y("sel3", 8'hEF, 4'hF);
      d = 8'h7F;
      expect_y("sel3_chg", 8'h7F, 4'hF);
      @(posedge clk) #1;
      expect_yq("sel3_reg", 8'h7F, 4'hF, 8'h7F, 4'hF);

      @(negedge clk);
      drive(2'd0, 8'h11, 8'h22, 8'h33, 8'h44);
      expect_y("sweep0", 8'h11, 4'h1);
      s = 2'd1;
      expect_y("sweep1", 8'h22, 4'h2);
      s = 2'd2;
      expect_y("sweep2", 8'h33, 4'h3);
      s = 2'd3;
      expect_y("sweep3", 8'h44, 4'h4);
      s = 2'd0;
      c = 8'hFF;
      expect_y("iso_c", 8'h11, 4'h1);
      b = 8'h00;
      d = 8'h9B;
      expect_y("iso_bd", 8'h11, 4'h1);

      @(negedge clk);
      drive(2'd2, 8'h00, 8'h00, 8'h44, 8'h00);
      @(posedge clk) #1;
      expect_yq("pre_mid_rst", 8'h44, 4'h4, 8'h44, 4'h4);
      rst_n = 1'b0;
      expect_yq("mid_rst_clear", 8'h44, 4'h4, 8'h00, 4'h0);
      @(posedge clk) #1;
      expect_yq("mid_rst_hold", 8'h44, 4'h4, 8'h00, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk) #1;
      expect_yq("mid_rst_release", 8'h44, 4'h4, 8'h44, 4'h4);

      #5;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mux_4to1_nb.md
# mux_4to1_nb

Parameterised N-bit-wide 4-to-1 bus multiplexer with a combinational output and a registered copy of that output. It is the lab-level data-selection primitive: instantiated at WIDTH=4 for nibble paths and WIDTH=8 for byte paths, fed by four data buses and a 2-bit select. The combinational path is the primary function. The registered output serves downstream synchronous logic that needs a glitch-free, clock-aligned value.

## Interface
Parameters:
- WIDTH, default 4: bit width of each data input and of both outputs; legal range is 1 or more.

Ports. Declaration order is iA, iB, iC, iD, iS, oY, iClk, iRst_n, oY_q, so existing positional instantiations (A, B, C, D, S, Y) remain valid.
- iClk  input  1  single clock, rising-edge active.
- iRst_n  input  1  reset; asynchronous and active-low.
- iA  input  WIDTH  data input, selected when iS=0.
- iB  input  WIDTH  data input, selected when iS=1.
- iC  input  WIDTH  data input, selected when iS=2.
- iD  input  WIDTH  data input, selected when iS=3.
- iS  input  2  select code.
- oY  output  WIDTH  combinational selected data.
- oY_q  output  WIDTH  registered selected data.

## Operation
- Selection: oY = iA when iS=2'b00, iB when 2'b01, iC when 2'b10, iD when 2'b11.
- oY is purely combinational. It has no dependence on iClk or iRst_n and is valid even while reset is asserted.
- iS containing X or Z: oY drives all-X in simulation. There is no default leg that masks a bad select.
- Width rules:
  - All data inputs and outputs are exactly WIDTH bits.
  - No sign extension or truncation happens inside the block.
  - Narrower instances are created by connecting sliced buses, for example the low nibble iA[3:0] into a WIDTH=4 instance.
- Registered path: on each rising edge of iClk with iRst_n high, oY_q takes the value oY had just before the edge.
- There is no enable. The register updates every cycle.
- Multiple instances with different WIDTH on shared inputs must behave independently and consistently. The low WIDTH bits of a wider instance's oY must equal the narrower instance's oY when both see the same low slices.

## Timing
- oY: zero-cycle latency. It follows any change on iA..iD or iS in the same delta/timestep.
- oY_q: one-cycle latency. Its value after rising edge k equals oY sampled at edge k.
- Reset assertion (iRst_n falling) clears oY_q to {WIDTH{1'b0}} immediately, with no clock required.
- While iRst_n is low, oY_q holds 0 regardless of clock or data.
- Release: the first rising edge after iRst_n goes high loads oY.
- Reset released coincident with a rising edge: that edge does not load; the next edge does.
- Reset asserted mid-operation affects only oY_q. oY keeps tracking its inputs.
- Reset values: oY_q = 0. oY has no reset value because it is combinational.

## Test plan
- Select 0 (iS=0, iA=8'hA3, iB=8'h24, iC=8'h7E, iD=8'h10) -> 8-bit oY=8'hA3 and 4-bit instance oY=4'h3. Then iA=8'h55 -> 8'h55 / 4'h5.
- Select 1 (iS=1, iA=8'h2C, iB=8'hE7, iC=8'h08, iD=8'hAA) -> 8'hE7 / 4'h7. Then iB=8'hD2 -> 8'hD2 / 4'h2.
- Select 2 (iS=2, iA=8'h00, iB=8'h67, iC=8'h1E, iD=8'hA8) -> 8'h1E / 4'hE. Then iC=8'h5C -> 8'h5C / 4'hC.
- Select 3 (iS=3, iA=8'hBE, iB=8'hDA, iC=8'hCE, iD=8'hEF) -> 8'hEF / 4'hF. Then iD=8'h7F -> 8'h7F / 4'hF.
- Select sweep and isolation: hold data fixed and step iS 0..3 with no clock. oY must change in the same timestep. Toggling an unselected input, for example iC while iS=0, must not change oY.
- Register and reset:
  - With iRst_n low, oY_q=0 through 3 clocks.
  - After release, with iS=2 and iC=8'h44, oY_q=8'h44 after the first edge.
  - Asserting iRst_n low between edges clears oY_q to 0 immediately while oY still reads 8'h44.
